mem_stage: RTL and testbench

//  RV32I pipeline memory stage; sits between ex_stage and wb_stage. Consumes ex_mem_reg, decodes loads and

---
 rtl/rv32i_types.sv | 68 ++++++
 rtl/mem_load_align.sv | 40 ++++
 rtl/mem_stage.sv | 207 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_types
// Description : Shared RV32I pipeline types: opcodes, funct3 encodings,
//               EX->MEM and MEM->WB bundles and the memory-stage state type.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_types;

    typedef enum logic [6:0] {
        op_b_lui   = 7'b0110111,
        op_b_auipc = 7'b0010111,
        op_b_jal   = 7'b1101111,
        op_b_jalr  = 7'b1100111,
        op_b_br    = 7'b1100011,
        op_b_load  = 7'b0000011,
        op_b_store = 7'b0100011,
        op_b_imm   = 7'b0010011,
        op_b_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        load_f3_lb  = 3'b000,
        load_f3_lh  = 3'b001,
        load_f3_lw  = 3'b010,
        load_f3_lbu = 3'b100,
        load_f3_lhu = 3'b101
    } load_f3_t;

    typedef enum logic [2:0] {
        store_f3_sb = 3'b000,
        store_f3_sh = 3'b001,
        store_f3_sw = 3'b010
    } store_f3_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [31:0] rs1_v;
        logic [31:0] rs2_v;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
        logic        commit;
    } ex_mem_reg_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [4:0]  rd_s;
        logic [31:0] rd_v;
        logic        regf_we;
        logic        commit;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } mem_wb_reg_t;

    typedef logic [0:0] mem_state_t;
    localparam mem_state_t S_IDLE = 1'b0;
    localparam mem_state_t S_WAIT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Selects the addressed byte/half of a load word and extends it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] rd_v
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        case (funct3)
            load_f3_lb:  rd_v = {{24{w_byte[7]}}, w_byte};
            load_f3_lbu: rd_v = {24'd0, w_byte};
            load_f3_lh:  rd_v = {{16{w_half[15]}}, w_half};
            load_f3_lhu: rd_v = {16'd0, w_half};
            default:     rd_v = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : RV32I memory stage: decodes loads/stores, runs the dmem
//               handshake, stalls upstream while an access is outstanding.
//               Optional macro MEM_STAGE_MISALIGN_CHECK_EN adds misalign_err.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  ex_mem_reg_t ex_mem_reg,
    output logic        stall,
    output mem_wb_reg_t mem_wb_reg,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    ,
    output logic        misalign_err
`endif
);

    mem_state_t  r_state;
    mem_wb_reg_t r_pend;
    logic [1:0]  r_off;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_i_imm;
    logic [31:0] w_s_imm;
    logic        w_is_load;
    logic        w_is_store;
    logic [31:0] w_ea;
    logic [1:0]  w_off;
    logic [3:0]  w_rmask;
    logic [3:0]  w_wmask;
    logic [31:0] w_wdata;
    logic        w_bad_f3;
    logic        w_misalign;
    logic        w_accept;
    logic [31:0] w_load_v;
    mem_wb_reg_t w_pass;
    mem_wb_reg_t w_done;

    assign w_opcode   = ex_mem_reg.inst[6:0];
    assign w_funct3   = ex_mem_reg.inst[14:12];
    assign w_i_imm    = {{20{ex_mem_reg.inst[31]}}, ex_mem_reg.inst[31:20]};
    assign w_s_imm    = {{20{ex_mem_reg.inst[31]}}, ex_mem_reg.inst[31:25], ex_mem_reg.inst[11:7]};
    assign w_is_load  = ex_mem_reg.commit && (w_opcode == op_b_load);
    assign w_is_store = ex_mem_reg.commit && (w_opcode == op_b_store);
    assign w_ea       = ex_mem_reg.rs1_v + (w_is_store ? w_s_imm : w_i_imm);
    assign w_off      = w_ea[1:0];
    assign w_wdata    = ex_mem_reg.rs2_v << {w_off, 3'b000};

    // Lanes past byte 3 fall off the 4-bit shift.
    always_comb begin
        w_rmask = 4'b0000;
        w_wmask = 4'b0000;
        if (w_is_load) begin
            case (w_funct3)
                load_f3_lb, load_f3_lbu: w_rmask = 4'b0001 << w_off;
                load_f3_lh, load_f3_lhu: w_rmask = 4'b0011 << w_off;
                load_f3_lw:              w_rmask = 4'b1111;
                default:                 w_rmask = 4'b0000;
            endcase
        end else if (w_is_store) begin
            case (w_funct3)
                store_f3_sb: w_wmask = 4'b0001 << w_off;
                store_f3_sh: w_wmask = 4'b0011 << w_off;
                store_f3_sw: w_wmask = 4'b1111;
                default:     w_wmask = 4'b0000;
            endcase
        end
    end

    assign w_bad_f3 = (w_is_load || w_is_store) && (w_rmask == 4'b0000) && (w_wmask == 4'b0000);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    always_comb begin
        w_misalign = 1'b0;
        if (w_is_load) begin
            case (w_funct3)
                load_f3_lh, load_f3_lhu: w_misalign = w_off[0];
                load_f3_lw:              w_misalign = (w_off != 2'b00);
                default:                 w_misalign = 1'b0;
            endcase
        end else if (w_is_store) begin
            case (w_funct3)
                store_f3_sh: w_misalign = w_off[0];
                store_f3_sw: w_misalign = (w_off != 2'b00);
                default:     w_misalign = 1'b0;
            endcase
        end
    end
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && !w_bad_f3 && !w_misalign &&
                      ((w_rmask != 4'b0000) || (w_wmask != 4'b0000));
    assign stall    = w_accept || ((r_state == S_WAIT) && !dmem_resp);

    always_comb begin
        dmem_addr  = 32'd0;
        dmem_rmask = 4'b0000;
        dmem_wmask = 4'b0000;
        dmem_wdata = 32'd0;
        if (r_state == S_WAIT) begin
            dmem_addr  = r_pend.mem_addr;
            dmem_rmask = r_pend.mem_rmask;
            dmem_wmask = r_pend.mem_wmask;
            dmem_wdata = r_pend.mem_wdata;
        end else if (w_accept) begin
            dmem_addr  = {w_ea[31:2], 2'b00};
            dmem_rmask = w_rmask;
            dmem_wmask = w_wmask;
            dmem_wdata = w_wdata;
        end
    end

    mem_load_align u_load_align (
        .funct3 (r_pend.inst[14:12]),
        .offset (r_off),
        .rdata  (dmem_rdata),
        .rd_v   (w_load_v)
    );

    always_comb begin
        w_pass         = '0;
        w_pass.pc      = ex_mem_reg.pc;
        w_pass.pc_next = ex_mem_reg.pc_next;
        w_pass.inst    = ex_mem_reg.inst;
        w_pass.rd_s    = ex_mem_reg.rd_s;
        w_pass.rd_v    = ex_mem_reg.rd_v;
        w_pass.regf_we = ex_mem_reg.regf_we && (ex_mem_reg.rd_s != 5'd0) && !w_bad_f3 && !w_misalign;
        w_pass.commit  = ex_mem_reg.commit;
    end

    always_comb begin
        w_done           = r_pend;
        w_done.commit    = 1'b1;
        w_done.mem_rdata = dmem_rdata;
        w_done.regf_we   = 1'b0;
        if (r_pend.mem_rmask != 4'b0000) begin
            w_done.rd_v    = w_load_v;
            w_done.regf_we = (r_pend.rd_s != 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pend     <= '0;
            r_off      <= 2'b00;
            mem_wb_reg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pend           <= w_pass;
                        r_pend.regf_we   <= 1'b0;
                        r_pend.commit    <= 1'b0;
                        r_pend.mem_addr  <= {w_ea[31:2], 2'b00};
                        r_pend.mem_rmask <= w_rmask;
                        r_pend.mem_wmask <= w_wmask;
                        r_pend.mem_wdata <= w_wdata;
                        r_off            <= w_off;
                        r_state          <= S_WAIT;
                        mem_wb_reg       <= '0;
                    end else begin
                        mem_wb_reg <= w_pass;
                    end
                end
                S_WAIT: begin
                    if (dmem_resp) begin
                        mem_wb_reg <= w_done;
                        r_state    <= S_IDLE;
                    end else begin
                        mem_wb_reg <= '0;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    mem_wb_reg <= '0;
                end
            endcase
        end
    end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= (r_state == S_IDLE) && w_misalign;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with directed load/store vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    import rv32i_types::*;

    localparam logic [6:0] c_op_load  = 7'b0000011;
    localparam logic [6:0] c_op_store = 7'b0100011;
    localparam logic [6:0] c_op_imm   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst;
    ex_mem_reg_t ex;
    logic        stall;
    mem_wb_reg_t mem_wb_reg;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rd_v;
        logic        we;
        logic [3:0]  rm;
        logic [3:0]  wm;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc_ctr = 32'h100;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mem_reg (ex),
        .stall      (stall),
        .mem_wb_reg (mem_wb_reg),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp)
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Any commit the scoreboard did not predict is itself a failure.
    always @(negedge clk) begin
        if (mem_wb_reg.commit === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got pc %h expected no commit", mem_wb_reg.pc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_pc", mem_wb_reg.pc, e.pc);
                chk("sb_rd_v", mem_wb_reg.rd_v, e.rd_v);
                chk("sb_regf_we", 32'(mem_wb_reg.regf_we), 32'(e.we));
                chk("sb_masks", {24'd0, mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask}, {24'd0, e.rm, e.wm});
            end
        end
    end

    function automatic logic [31:0] i_inst(input logic [11:0] imm, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] op);
        return {imm, 5'd1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_inst(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], c_op_store};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_ex(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic [31:0] rdv, input logic we);
        ex         = '0;
        ex.pc      = pc_ctr;
        ex.pc_next = pc_ctr + 32'd4;
        ex.inst    = inst;
        ex.rs1_v   = rs1;
        ex.rs2_v   = rs2;
        ex.rd_s    = rd;
        ex.rd_v    = rdv;
        ex.regf_we = we;
        ex.commit  = 1'b1;
    endtask

    // Non-request op: one-cycle pass-through.
    task automatic pass_op(input string name, input logic [31:0] inst, input logic [31:0] rs1,
                           input logic [4:0] rd, input logic [31:0] rdv, input logic e_we);
        new_ex(inst, rs1, 32'd0, rd, rdv, 1'b1);
        q.push_back('{pc: pc_ctr, rd_v: rdv, we: e_we, rm: 4'd0, wm: 4'd0});
        #1;
        chk({name, "_stall"}, 32'(stall), 32'd0);
        chk({name, "_nomask"}, {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        step();
        ex = '0;
        pc_ctr += 32'd4;
    endtask

    task automatic mem_txn(input string name, input logic [31:0] inst, input logic [31:0] rs1,
                           input logic [31:0] rs2, input logic [4:0] rd,
                           input logic [31:0] e_addr, input logic [3:0] e_rm, input logic [3:0] e_wm,
                           input logic [31:0] e_wd, input int delay, input logic [31:0] rdata,
                           input logic [31:0] e_rdv, input logic e_we);
        new_ex(inst, rs1, rs2, rd, 32'd0, (e_rm != 4'd0));
        q.push_back('{pc: pc_ctr, rd_v: e_rdv, we: e_we, rm: e_rm, wm: e_wm});
        #1;
        chk({name, "_req_stall"}, 32'(stall), 32'd1);
        chk({name, "_addr"}, dmem_addr, e_addr);
        chk({name, "_masks"}, {24'd0, dmem_rmask, dmem_wmask}, {24'd0, e_rm, e_wm});
        if (e_wm != 4'd0) chk({name, "_wdata"}, dmem_wdata, e_wd);
        for (int i = 1; i < delay; i++) begin
            step();
            chk({name, "_wait_stall"}, 32'(stall), 32'd1);
            chk({name, "_wait_addr"}, dmem_addr, e_addr);
            chk({name, "_bubble"}, 32'(mem_wb_reg.commit), 32'd0);
        end
        step();
        dmem_resp  = 1'b1;
        dmem_rdata = rdata;
        #1;
        chk({name, "_resp_stall"}, 32'(stall), 32'd0);
        step();
        dmem_resp = 1'b0;
        ex        = '0;
        #1;
        chk({name, "_masks_clear"}, {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        pc_ctr += 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        ex         = '0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        repeat (3) step();
        chk("rst_commit", 32'(mem_wb_reg.commit), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        rst = 1'b0;
        step();

        pass_op("addi", i_inst(12'd5, 3'b000, 5'd5, c_op_imm), 32'd0, 5'd5, 32'd5, 1'b1);
        pass_op("addi_x0", i_inst(12'd9, 3'b000, 5'd0, c_op_imm), 32'd0, 5'd0, 32'd9, 1'b0);

        mem_txn("lw", i_inst(12'd4, 3'b010, 5'd7, c_op_load), 32'h1000, 32'd0, 5'd7,
                32'h1004, 4'b1111, 4'b0000, 32'd0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1);
        mem_txn("lb", i_inst(12'd3, 3'b000, 5'd8, c_op_load), 32'h1000, 32'd0, 5'd8,
                32'h1000, 4'b1000, 4'b0000, 32'd0, 1, 32'h80123456, 32'hFFFFFF80, 1'b1);
        mem_txn("lbu", i_inst(12'd3, 3'b100, 5'd8, c_op_load), 32'h1000, 32'd0, 5'd8,
                32'h1000, 4'b1000, 4'b0000, 32'd0, 1, 32'h80123456, 32'h00000080, 1'b1);
        mem_txn("sh", s_inst(12'd2, 3'b001), 32'h2000, 32'h1234ABCD, 5'd0,
                32'h2000, 4'b0000, 4'b1100, 32'hABCD0000, 2, 32'd0, 32'd0, 1'b0);
        mem_txn("lh", i_inst(12'd2, 3'b001, 5'd9, c_op_load), 32'h3000, 32'd0, 5'd9,
                32'h3000, 4'b1100, 4'b0000, 32'd0, 1, 32'h80017777, 32'hFFFF8001, 1'b1);
        mem_txn("lhu", i_inst(12'd0, 3'b101, 5'd9, c_op_load), 32'h3000, 32'd0, 5'd9,
                32'h3000, 4'b0011, 4'b0000, 32'd0, 1, 32'h1234F00D, 32'h0000F00D, 1'b1);
        mem_txn("sw_wrap", s_inst(12'hFF0, 3'b010), 32'h10, 32'hCAFEF00D, 5'd0,
                32'h0, 4'b0000, 4'b1111, 32'hCAFEF00D, 1, 32'd0, 32'd0, 1'b0);
        mem_txn("lw_x0", i_inst(12'd0, 3'b010, 5'd0, c_op_load), 32'h4000, 32'd0, 5'd0,
                32'h4000, 4'b1111, 4'b0000, 32'd0, 1, 32'h11223344, 32'h11223344, 1'b0);

        pass_op("bad_f3", i_inst(12'd0, 3'b011, 5'd3, c_op_load), 32'h1000, 5'd3, 32'h55, 1'b0);

        // Reset during an outstanding access, response arrives afterwards.
        new_ex(i_inst(12'd0, 3'b010, 5'd6, c_op_load), 32'h5000, 32'd0, 5'd6, 32'd0, 1'b1);
        #1;
        chk("rstw_req_stall", 32'(stall), 32'd1);
        step();
        rst = 1'b1;
        ex  = '0;
        step();
        rst        = 1'b0;
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h99999999;
        #1;
        chk("rstw_stall", 32'(stall), 32'd0);
        chk("rstw_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        step();
        dmem_resp = 1'b0;
        chk("rstw_commit", 32'(mem_wb_reg.commit), 32'd0);
        step();
        chk("rstw_idle_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        pc_ctr += 32'd4;

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
        new_ex(i_inst(12'd2, 3'b010, 5'd4, c_op_load), 32'h1000, 32'd0, 5'd4, 32'd0, 1'b1);
        q.push_back('{pc: pc_ctr, rd_v: 32'd0, we: 1'b0, rm: 4'd0, wm: 4'd0});
        #1;
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_masks", {24'd0, dmem_rmask, dmem_wmask}, 32'd0);
        step();
        ex = '0;
        chk("mis_err", 32'(misalign_err), 32'd1);
        step();
        chk("mis_err_clear", 32'(misalign_err), 32'd0);
        pc_ctr += 32'd4;
`else
        mem_txn("lh_trunc", i_inst(12'd3, 3'b001, 5'd4, c_op_load), 32'h1000, 32'd0, 5'd4,
                32'h1000, 4'b1000, 4'b0000, 32'd0, 1, 32'hAB000000, 32'hFFFFAB00, 1'b1);
`endif

        repeat (3) step();
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
